fifo_umbrales: RTL
==================

# fifo_umbrales

Parametrised FIFO with programmable almost-full/almost-empty thresholds (umbrales) and a control state machine (RESET, INIT, IDLE, ACTIVE, ERROR). It is the generalised successor of the fixed-size FIFOs in the transaction layer. It is instantiated once per main-FIFO, virtual-channel or destination buffer. Its `pause` output feeds upstream flow control, and its `can_pop` output feeds downstream arbiters.

## Interface
Parameters:
- `BITNUMBER`, 8, data width in bits.
- `DEPTH_LOG2`, 3, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2).
- `CNT_W`, DEPTH_LOG2+1, width of occupancy count and thresholds.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `init`  in  1  enter INIT and load thresholds.
- `umbral_alto`  in  CNT_W  almost-full threshold, sampled in INIT.
- `umbral_bajo`  in  CNT_W  almost-empty threshold, sampled in INIT.
- `push`  in  1  write `data_in` this cycle.
- `data_in`  in  BITNUMBER  write data.
- `pop`  in  1  read request this cycle.
- `data_out`  out  BITNUMBER  registered read data.
- `valid_out`  out  1  `data_out` valid (one cycle per accepted pop).
- `count`  out  CNT_W  current occupancy.
- `full`, `empty`  out  1  count==DEPTH / count==0.
- `pause`  out  1  almost full: count >= latched umbral_alto.
- `almost_empty`  out  1  count <= latched umbral_bajo.
- `can_pop`  out  1  `!empty` and state is IDLE or ACTIVE.
- `error`  out  1  asserted while in ERROR.
- `state`  out  5  one-hot state: RESET=00001, INIT=00010, IDLE=00100, ACTIVE=01000, ERROR=10000.

## Operation
- Reset (async) forces the following:
  - state=RESET, count=0, read/write pointers=0, data_out=0, valid_out=0, error=0.
  - Latched thresholds: alto=DEPTH, bajo=0.
  - Hence empty=1, full=0, pause=1 only if DEPTH>=... (no: pause=0 since count 0 < DEPTH), almost_empty=1, can_pop=0.
- State transitions:
  - RESET: first edge with reset low goes to INIT.
  - INIT: on every edge, latch thresholds. umbral_alto is clamped: a value >DEPTH or 0 is stored as DEPTH. umbral_bajo is stored as-is. Pointers and count are cleared. Stay in INIT while `init`=1; go to IDLE when `init`=0.
  - IDLE: accepted push goes to ACTIVE.
  - ACTIVE: goes to IDLE on an edge where the resulting count is 0.
  - Any state except RESET: `init`=1 goes to INIT (highest priority after reset).
  - IDLE/ACTIVE: overflow or underflow goes to ERROR. Overflow is push with full=1 and no pop. Underflow is pop with empty=1.
  - ERROR: sticky. Leaves only via reset or `init`.
- push/pop are honoured only in IDLE and ACTIVE. They are ignored in RESET, INIT and ERROR (count and memory unchanged, valid_out=0).
- Simultaneous push and pop:
  - When full: both accepted, count unchanged, no error.
  - When empty: underflow, so ERROR; the push is discarded too (no bypass).
  - Otherwise: both accepted, count unchanged.
- Pointers wrap modulo DEPTH. count is CNT_W bits and never exceeds DEPTH.
- The erroneous operation is not performed: memory and count are untouched on the error edge.

## Timing
- Push at edge N: data is stored at N, and count/flags update after N.
- Pop accepted at edge N: data_out is loaded and valid_out=1 after N, for one cycle. data_out holds its value when valid_out=0.
- Latency from push to earliest pop result is 2 edges.
- full, empty, pause, almost_empty and can_pop are combinational from registered count/state/thresholds. No extra latency.
- Thresholds written in INIT take effect on flags from the cycle after the latch edge.
- Reset mid-operation clears everything immediately, without waiting for a clock edge. The stored memory contents are don't-care.

## Test plan
- Reset then init: hold reset 2 cycles, then assert init=1 with alto=3, bajo=1 for 1 cycle, then init=0. Required: state RESET, then INIT, then IDLE; empty=1, almost_empty=1, pause=0, can_pop=0 throughout INIT.
- Fill to threshold: alto=3, bajo=1, DEPTH=8; push 0xA1,0xA2,0xA3. Required: count 1,2,3; almost_empty drops after count=2; pause rises after the third push; state ACTIVE after the first push.
- Drain in order: from the previous case, pop 3 times. Required: data_out 0xA1,0xA2,0xA3 with valid_out=1 on each cycle after a pop; count reaches 0; state returns to IDLE.
- Full with simultaneous push/pop: push 8 words (0x10..0x17). Then, with full=1, push 0x18 and pop together. Required: count stays 8, data_out=0x10, no error. Then 8 pops return 0x11..0x18, exercising pointer wrap.
- Overflow/underflow: push with full=1 and no pop gives error=1, state ERROR, count=8 unchanged. Further push/pop are ignored. init=1 then clears to INIT with count=0. Separately, pop on empty in IDLE gives ERROR.
- Async reset mid-stream: assert reset between clock edges with count=5. Required: count=0, state=RESET and valid_out=0 immediately, before the next edge.

Source files
------------

// File: rtl/fifo_umbrales.sv
// FIFO with programmable almost-full/almost-empty thresholds and a one-hot control FSM.
// Pop data is registered (1 edge); flags are combinational from registered count/state.
module fifo_umbrales #(
    parameter int BITNUMBER  = 8,
    parameter int DEPTH_LOG2 = 3,
    parameter int CNT_W      = DEPTH_LOG2 + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [CNT_W-1:0]     umbral_alto,
    input  logic [CNT_W-1:0]     umbral_bajo,
    input  logic                 push,
    input  logic [BITNUMBER-1:0] data_in,
    input  logic                 pop,
    output logic [BITNUMBER-1:0] data_out,
    output logic                 valid_out,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty,
    output logic                 pause,
    output logic                 almost_empty,
    output logic                 can_pop,
    output logic                 error,
    output logic [4:0]           state
);

    localparam int              DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    state_t st, st_nx;

    logic [BITNUMBER-1:0]  mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic [CNT_W-1:0]      alto_q, bajo_q, alto_clamped;
    logic                  op_en, overflow, underflow, do_push, do_pop, clear;

    // A zero or out-of-range high threshold would make pause meaningless; pin it to DEPTH.
    assign alto_clamped = (umbral_alto == '0 || umbral_alto > DEPTH_CNT) ? DEPTH_CNT : umbral_alto;

    assign full         = (cnt == DEPTH_CNT);
    assign empty        = (cnt == '0);
    assign pause        = (cnt >= alto_q);
    assign almost_empty = (cnt <= bajo_q);
    assign can_pop      = !empty && (st == ST_IDLE || st == ST_ACTIVE);
    assign error        = (st == ST_ERROR);
    assign count        = cnt;
    assign state        = st;

    always_comb begin
        op_en     = (st == ST_IDLE || st == ST_ACTIVE) && !init;
        underflow = op_en && pop && empty;
        overflow  = op_en && push && full && !pop;
        // An underflowing pop also discards a simultaneous push: no empty bypass.
        do_push   = op_en && push && !underflow && !overflow;
        do_pop    = op_en && pop && !empty;
        clear     = (st == ST_INIT) || (init && st != ST_RESET);
    end

    always_comb begin
        cnt_nx = cnt;
        case ({do_push, do_pop})
            2'b10:   cnt_nx = cnt + CNT_W'(1);
            2'b01:   cnt_nx = cnt - CNT_W'(1);
            default: cnt_nx = cnt;
        endcase
    end

    always_comb begin
        st_nx = st;
        case (st)
            ST_RESET: st_nx = ST_INIT;
            ST_INIT:  st_nx = init ? ST_INIT : ST_IDLE;
            ST_IDLE: begin
                if (init)                       st_nx = ST_INIT;
                else if (underflow || overflow) st_nx = ST_ERROR;
                else if (do_push)               st_nx = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)                       st_nx = ST_INIT;
                else if (underflow || overflow) st_nx = ST_ERROR;
                else if (cnt_nx == '0)          st_nx = ST_IDLE;
            end
            ST_ERROR: if (init) st_nx = ST_INIT;
            default:  st_nx = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= ST_RESET;
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            alto_q    <= DEPTH_CNT;
            bajo_q    <= '0;
        end else begin
            st        <= st_nx;
            valid_out <= do_pop;
            if (st == ST_INIT) begin
                alto_q <= alto_clamped;
                bajo_q <= umbral_bajo;
            end
            if (clear) begin
                cnt    <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                cnt <= cnt_nx;
                if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                if (do_pop) begin
                    rd_ptr   <= rd_ptr + DEPTH_LOG2'(1);
                    data_out <= mem[rd_ptr];
                end
            end
        end
    end

    // Storage is not reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

endmodule
